// File: rtl/id_ex_alu_stage.sv
// ID/EX pipeline register feeding the RV32I execute stage: ALU, branch resolution and target.
// Optional operand forwarding ports are enabled with `define ID_EX_ALU_FORWARD_EN.
module id_ex_alu_stage #(
    parameter int              XLEN     = 32,
    parameter logic [XLEN-1:0] RESET_PC = 32'h0
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            StallE,
    input  logic            FlushE,
    input  logic            ValidD,
    input  logic [3:0]      ALUControlD,
    input  logic            ALUSrcD,
    input  logic            BranchD,
    input  logic            JumpD,
    input  logic            JalrD,
    input  logic            RegWriteD,
    input  logic [4:0]      RdD,
    input  logic [XLEN-1:0] RD1D,
    input  logic [XLEN-1:0] RD2D,
    input  logic [XLEN-1:0] ImmExtD,
    input  logic [XLEN-1:0] PCD,
    input  logic [XLEN-1:0] PCPlus4D,
`ifdef ID_EX_ALU_FORWARD_EN
    input  logic [1:0]      ForwardAE,
    input  logic [1:0]      ForwardBE,
    input  logic [XLEN-1:0] ALUResultM,
    input  logic [XLEN-1:0] ResultW,
`endif
    output logic            ValidE,
    output logic            RegWriteE,
    output logic [4:0]      RdE,
    output logic [XLEN-1:0] ALUResultE,
    output logic [XLEN-1:0] WriteDataE,
    output logic [XLEN-1:0] PCPlus4E,
    output logic [XLEN-1:0] PCTargetE,
    output logic            PCSrcE
);

    logic            valid_reg;
    logic [3:0]      alu_control_reg;
    logic            alu_src_reg;
    logic            branch_reg;
    logic            jump_reg;
    logic            jalr_reg;
    logic            reg_write_reg;
    logic [4:0]      rd_reg;
    logic [XLEN-1:0] rd1_reg;
    logic [XLEN-1:0] rd2_reg;
    logic [XLEN-1:0] imm_reg;
    logic [XLEN-1:0] pc_reg;
    logic [XLEN-1:0] pc_plus4_reg;

    // Flush outranks stall so a redirect can squash a held instruction.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n || FlushE) begin
            valid_reg       <= 1'b0;
            alu_control_reg <= 4'b0000;
            alu_src_reg     <= 1'b0;
            branch_reg      <= 1'b0;
            jump_reg        <= 1'b0;
            jalr_reg        <= 1'b0;
            reg_write_reg   <= 1'b0;
            rd_reg          <= 5'd0;
            rd1_reg         <= '0;
            rd2_reg         <= '0;
            imm_reg         <= '0;
            pc_reg          <= RESET_PC;
            pc_plus4_reg    <= RESET_PC;
        end else if (!StallE) begin
            valid_reg       <= ValidD;
            alu_control_reg <= ALUControlD;
            alu_src_reg     <= ALUSrcD;
            branch_reg      <= BranchD;
            jump_reg        <= JumpD;
            jalr_reg        <= JalrD;
            reg_write_reg   <= RegWriteD;
            rd_reg          <= RdD;
            rd1_reg         <= RD1D;
            rd2_reg         <= RD2D;
            imm_reg         <= ImmExtD;
            pc_reg          <= PCD;
            pc_plus4_reg    <= PCPlus4D;
        end
    end

    logic [XLEN-1:0] fwd_a;
    logic [XLEN-1:0] fwd_b;

`ifdef ID_EX_ALU_FORWARD_EN
    always_comb begin
        case (ForwardAE)
            2'b01:   fwd_a = ResultW;
            2'b10:   fwd_a = ALUResultM;
            default: fwd_a = rd1_reg;
        endcase
        case (ForwardBE)
            2'b01:   fwd_b = ResultW;
            2'b10:   fwd_b = ALUResultM;
            default: fwd_b = rd2_reg;
        endcase
    end
`else
    assign fwd_a = rd1_reg;
    assign fwd_b = rd2_reg;
`endif

    logic [XLEN-1:0] src_a;
    logic [XLEN-1:0] src_b;
    logic [4:0]      shamt;
    logic [XLEN-1:0] alu_result;
    logic            taken;
    logic [XLEN-1:0] jalr_sum;

    assign src_a = fwd_a;
    assign src_b = alu_src_reg ? imm_reg : fwd_b;
    assign shamt = src_b[4:0];

    always_comb begin
        alu_result = src_a + src_b;
        if (!branch_reg) begin
            case (alu_control_reg)
                4'b1000: alu_result = src_a - src_b;
                4'b0001,
                4'b1001: alu_result = src_a << shamt;
                4'b0101,
                4'b1101: alu_result = {{(XLEN-1){1'b0}}, ($signed(src_a) < $signed(src_b))};
                4'b0111,
                4'b1111: alu_result = {{(XLEN-1){1'b0}}, (src_a < src_b)};
                4'b0100,
                4'b1100: alu_result = src_a ^ src_b;
                4'b0011,
                4'b1011: alu_result = src_a | src_b;
                4'b0010,
                4'b1010: alu_result = src_a & src_b;
                4'b0110: alu_result = src_a >> shamt;
                4'b1110: alu_result = $unsigned($signed(src_a) >>> shamt);
                default: alu_result = src_a + src_b;
            endcase
        end
    end

    // Branches compare the register operands, never the immediate.
    always_comb begin
        case (alu_control_reg[2:0])
            3'b000:  taken = (fwd_a == fwd_b);
            3'b001:  taken = (fwd_a != fwd_b);
            3'b100:  taken = ($signed(fwd_a) < $signed(fwd_b));
            3'b101:  taken = ($signed(fwd_a) >= $signed(fwd_b));
            3'b110:  taken = (fwd_a < fwd_b);
            3'b111:  taken = (fwd_a >= fwd_b);
            default: taken = 1'b0;
        endcase
    end

    assign jalr_sum   = fwd_a + imm_reg;
    assign PCTargetE  = jalr_reg ? {jalr_sum[XLEN-1:1], 1'b0} : (pc_reg + imm_reg);
    assign PCSrcE     = valid_reg & (jump_reg | (branch_reg & taken));
    assign ValidE     = valid_reg;
    assign RegWriteE  = reg_write_reg & valid_reg;
    assign RdE        = rd_reg;
    assign ALUResultE = alu_result;
    assign WriteDataE = fwd_b;
    assign PCPlus4E   = pc_plus4_reg;

endmodule
